// File: rtl/tdc_avg_pkg.sv
// Shared widths, types and constants for the TDC result averager.
// Packages cannot be parameterised, so the width helpers are functions and the localparams give the default build.
package tdc_avg_pkg;

    localparam int INT_W = 10;
    localparam int FRAC_W = 7;
    localparam int DEF_LOG2_N = 4;
    localparam int DEF_FRAC_SHIFT = 6;

    function automatic int comb_width(input int frac_shift);
        return INT_W + frac_shift + 1;
    endfunction

    function automatic int acc_width(input int frac_shift, input int log2_n);
        return comb_width(frac_shift) + log2_n;
    endfunction

    localparam int COMB_W = comb_width(DEF_FRAC_SHIFT);
    localparam int ACC_W = acc_width(DEF_FRAC_SHIFT, DEF_LOG2_N);

    typedef logic [COMB_W-1:0] comb_t;

    localparam logic [7:0] OVF_SAT = 8'd255;

endpackage

// File: rtl/tdc_avg_fifo.sv
// First-word-fall-through FIFO for block means.
// The head is presented combinationally, and it reads as zero while the FIFO is empty.
module tdc_avg_fifo
    import tdc_avg_pkg::*;
#(
    parameter int WIDTH = 17,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  push,
    input  logic [WIDTH-1:0]      din,
    input  logic                  pop,
    output logic [WIDTH-1:0]      dout,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  full,
    output logic                  empty
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [DEPTH_LOG2:0]   level_reg;
    logic                  do_push, do_pop;

    assign empty = (level_reg == '0);
    assign full = (level_reg == (DEPTH_LOG2+1)'(DEPTH));
    assign level = level_reg;
    assign dout = empty ? '0 : mem[rd_ptr_reg];

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_pop = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop) rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level_reg <= level_reg + 1'b1;
                2'b01:   level_reg <= level_reg - 1'b1;
                default: level_reg <= level_reg;
            endcase
        end
    end

endmodule

// File: rtl/tdc_result_averager.sv
// Merges TDC int/frac results, averages blocks of 2^LOG2_N with round-half-up and queues the means.
// Optional block min/max outputs are enabled by defining TDC_AVG_MINMAX_EN.
module tdc_result_averager
    import tdc_avg_pkg::*;
#(
    parameter int LOG2_N = 4,
    parameter int FRAC_SHIFT = 6,
    parameter int FIFO_DEPTH_LOG2 = 3,
    localparam int CW = comb_width(FRAC_SHIFT)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [FRAC_W-1:0]          frac_part,
    input  logic [INT_W-1:0]           int_part,
    input  logic                       wrena,
    input  logic                       clear,
    output logic [CW-1:0]              avg_data,
    output logic                       avg_valid,
    input  logic                       avg_ready,
    output logic [FIFO_DEPTH_LOG2:0]   fifo_level,
    output logic [7:0]                 overflow_cnt
`ifdef TDC_AVG_MINMAX_EN
    ,
    output logic [CW-1:0]              blk_min,
    output logic [CW-1:0]              blk_max
`endif
);
    localparam int AW = acc_width(FRAC_SHIFT, LOG2_N);
    localparam int CNT_W = (LOG2_N > 0) ? LOG2_N : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'((1 << LOG2_N) - 1);
    localparam logic [AW:0] RND = (AW+1)'((1 << LOG2_N) >> 1);

    logic [CW-1:0]    s1_val_reg;
    logic             s1_v_reg;
    logic [AW-1:0]    acc_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [7:0]       ovf_reg;
    logic [AW:0]      sum;
    logic [CW-1:0]    mean;
    logic             blk_last, pop, fifo_full, fifo_empty, drop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_val_reg <= '0;
            s1_v_reg <= 1'b0;
        end else begin
            s1_val_reg <= (CW'(int_part) << FRAC_SHIFT) + CW'(frac_part);
            s1_v_reg <= wrena && !clear;
        end
    end

    // The extra sum bit keeps the rounding term from wrapping a full-scale block.
    assign sum = {1'b0, acc_reg} + (AW+1)'(s1_val_reg) + RND;
    assign mean = CW'(sum >> LOG2_N);
    assign blk_last = s1_v_reg && (cnt_reg == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_reg <= '0;
            cnt_reg <= '0;
        end else if (clear) begin
            acc_reg <= '0;
            cnt_reg <= '0;
        end else if (blk_last) begin
            acc_reg <= '0;
            cnt_reg <= '0;
        end else if (s1_v_reg) begin
            acc_reg <= acc_reg + AW'(s1_val_reg);
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign pop = avg_valid && avg_ready;
    assign drop = blk_last && fifo_full && !pop;
    assign avg_valid = !fifo_empty;

    tdc_avg_fifo #(
        .WIDTH      (CW),
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (clear),
        .push  (blk_last),
        .din   (mean),
        .pop   (pop),
        .dout  (avg_data),
        .level (fifo_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_reg <= '0;
        end else if (clear) begin
            ovf_reg <= '0;
        end else if (drop && (ovf_reg != OVF_SAT)) begin
            ovf_reg <= ovf_reg + 1'b1;
        end
    end

    assign overflow_cnt = ovf_reg;

`ifdef TDC_AVG_MINMAX_EN
    logic [CW-1:0] run_min_reg, run_max_reg, cur_min, cur_max;

    assign cur_min = (s1_val_reg < run_min_reg) ? s1_val_reg : run_min_reg;
    assign cur_max = (s1_val_reg > run_max_reg) ? s1_val_reg : run_max_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_min_reg <= '1;
            run_max_reg <= '0;
            blk_min <= '0;
            blk_max <= '0;
        end else if (clear) begin
            run_min_reg <= '1;
            run_max_reg <= '0;
        end else if (blk_last) begin
            blk_min <= cur_min;
            blk_max <= cur_max;
            run_min_reg <= '1;
            run_max_reg <= '0;
        end else if (s1_v_reg) begin
            run_min_reg <= cur_min;
            run_max_reg <= cur_max;
        end
    end
`endif

endmodule

// File: tb/tb_tdc_result_averager.sv
// Scoreboard bench: stimulus pushes expected block means, a monitor pops them on every DUT readout.
module tb_tdc_result_averager;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [6:0]  frac_part = '0;
    logic [9:0]  int_part = '0;
    logic        wrena = 1'b0;
    logic        clear = 1'b0;
    logic        avg_ready = 1'b0;
    logic [16:0] avg_data;
    logic        avg_valid;
    logic [3:0]  fifo_level;
    logic [7:0]  overflow_cnt;
`ifdef TDC_AVG_MINMAX_EN
    logic [16:0] blk_min, blk_max;
`endif

    int checks = 0;
    int fails = 0;
    int exp_q[$];
    int blk_q[$];
    bit expect_drop = 1'b0;
    int mon_exp;

    always #5 clk = ~clk;

    tdc_result_averager #(
        .LOG2_N          (2),
        .FRAC_SHIFT      (6),
        .FIFO_DEPTH_LOG2 (3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .frac_part    (frac_part),
        .int_part     (int_part),
        .wrena        (wrena),
        .clear        (clear),
        .avg_data     (avg_data),
        .avg_valid    (avg_valid),
        .avg_ready    (avg_ready),
        .fifo_level   (fifo_level),
        .overflow_cnt (overflow_cnt)
`ifdef TDC_AVG_MINMAX_EN
        ,
        .blk_min      (blk_min),
        .blk_max      (blk_max)
`endif
    );

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: actual %0d required %0d", name, act, req);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    // Reference: a block mean is floor((sum of 4 samples + 2) / 4).
    task automatic send(input int ip, input int fp);
        int s;
        wrena = 1'b1;
        int_part = ip[9:0];
        frac_part = fp[6:0];
        blk_q.push_back(ip * 64 + fp);
        if (blk_q.size() == 4) begin
            s = 0;
            foreach (blk_q[k]) s += blk_q[k];
            if (!expect_drop) exp_q.push_back((s + 2) / 4);
            blk_q.delete();
        end
        @(posedge clk); #1;
        wrena = 1'b0;
    endtask

    task automatic send_val(input int v);
        send(v / 64, v % 64);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send_rand_block();
        for (int i = 0; i < 4; i++) send($urandom_range(0, 1023), $urandom_range(0, 126));
    endtask

    task automatic drain();
        int n;
        n = 0;
        avg_ready = 1'b1;
        while ((avg_valid || exp_q.size() != 0) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        avg_ready = 1'b0;
        check("drain_level", int'(fifo_level), 0);
        check("drain_leftover", exp_q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (rst && avg_valid && avg_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL pop_unexpected: actual %0d required none", avg_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (int'(avg_data) !== mon_exp) begin
                    fails++;
                    $display("FAIL pop_data: actual %0d required %0d", avg_data, mon_exp);
                end else begin
                    $display("ok   pop_data: %0d", avg_data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: actual timeout required finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        idle(2);
        check("rst_valid", int'(avg_valid), 0);
        check("rst_level", int'(fifo_level), 0);
        check("rst_ovf", int'(overflow_cnt), 0);
        check("rst_data", int'(avg_data), 0);
        rst = 1'b1;
        idle(2);

        // Basic mean and 2-cycle latency
        send(3, 10); send(3, 14); send(3, 18); send(3, 22);
        check("lat_t1_valid", int'(avg_valid), 0);
        idle(1);
        check("lat_t2_valid", int'(avg_valid), 1);
        check("basic_data", int'(avg_data), 208);
        check("basic_level", int'(fifo_level), 1);
        idle(1);
        drain();

        // Rounding
        avg_ready = 1'b1;
        send_val(202); send_val(202); send_val(203); send_val(203);
        send_val(202); send_val(202); send_val(202); send_val(203);
        idle(3);
        drain();

        // Back-to-back strobes
        for (int i = 0; i < 16; i++) send_val(100);
        idle(2);
        check("b2b_level", int'(fifo_level), 4);
        check("b2b_ovf", int'(overflow_cnt), 0);
        drain();

        // Overflow: blocks 9 and 10 are dropped
        for (int b = 0; b < 10; b++) begin
            expect_drop = (b >= 8);
            send_rand_block();
        end
        expect_drop = 1'b0;
        idle(2);
        check("ovf_level", int'(fifo_level), 8);
        check("ovf_cnt", int'(overflow_cnt), 2);
        drain();

        // Full FIFO with push and pop in the same cycle
        for (int b = 0; b < 8; b++) send_rand_block();
        idle(2);
        check("full_level_pre", int'(fifo_level), 8);
        for (int i = 0; i < 3; i++) send($urandom_range(0, 1023), $urandom_range(0, 126));
        send($urandom_range(0, 1023), $urandom_range(0, 126));
        avg_ready = 1'b1;
        idle(1);
        avg_ready = 1'b0;
        idle(1);
        check("full_pushpop_level", int'(fifo_level), 8);
        check("full_pushpop_ovf", int'(overflow_cnt), 2);
        drain();

        // Randomised traffic with mostly-ready consumer
        for (int c = 0; c < 300; c++) begin
            avg_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1)
                send($urandom_range(0, 1023), $urandom_range(0, 126));
            else
                idle(1);
        end
        idle(3);
        drain();
        check("rand_ovf", int'(overflow_cnt), 2);

        // Clear in the cycle of a block's 3rd strobe
        send_rand_block();
        idle(2);
        check("clr_pre_level", int'(fifo_level), 1);
        send_rand_block();
        send_val(300); send_val(301);
        clear = 1'b1;
        send_val(302);
        clear = 1'b0;
        blk_q.delete();
        exp_q.delete();
        idle(2);
        check("clr_level", int'(fifo_level), 0);
        check("clr_valid", int'(avg_valid), 0);
        check("clr_ovf", int'(overflow_cnt), 0);
        send_val(500); send_val(600); send_val(700);
        idle(2);
        check("clr_fresh3_level", int'(fifo_level), 0);
        send_val(801);
        idle(2);
        check("clr_fresh4_level", int'(fifo_level), 1);
        drain();

        // Asynchronous reset mid-block
        send_rand_block();
        idle(2);
        send_val(1000); send_val(2000);
        #3;
        rst = 1'b0;
        #1;
        check("arst_valid", int'(avg_valid), 0);
        check("arst_level", int'(fifo_level), 0);
        check("arst_data", int'(avg_data), 0);
        check("arst_ovf", int'(overflow_cnt), 0);
        exp_q.delete();
        blk_q.delete();
        @(posedge clk); #1;
        rst = 1'b1;
        idle(1);
        send_val(4000); send_val(4001); send_val(4002); send_val(4004);
        idle(2);
        check("arst_after_level", int'(fifo_level), 1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/tdc_result_averager.md
Name: tdc_result_averager

Overview:
- Sits directly downstream of the TDC time counter and consumes its frac_part / int_part / wrena result stream.
- Merges each result into one fixed-point fine-time word.
- Averages blocks of 2^LOG2_N consecutive results with round-half-up.
- Buffers block means in a first-word-fall-through FIFO with a valid/ready readout for the capture/transfer logic.

Parameters:
- LOG2_N, default 4: log2 of samples per averaging block; legal range 0..8.
- FRAC_SHIFT, default 6: log2 of fine LSBs per integer clock period; combined = (int_part << FRAC_SHIFT) + frac_part.
- FIFO_DEPTH_LOG2, default 3: log2 of result FIFO depth, so default depth is 8 entries.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- frac_part  in  7  fractional sum from the time counter, 0..126.
- int_part  in  10  integer period count from the time counter.
- wrena  in  1  one-cycle strobe qualifying frac_part/int_part.
- clear  in  1  synchronous flush of the whole block.
- avg_data  out  COMB_W  block mean, fine LSBs; COMB_W = 10+FRAC_SHIFT+1.
- avg_valid  out  1  FIFO head valid.
- avg_ready  in  1  consumer pop; a pop occurs when avg_valid && avg_ready.
- fifo_level  out  FIFO_DEPTH_LOG2+1  current number of FIFO entries.
- overflow_cnt  out  8  count of block means dropped because the FIFO was full; saturates at 255.

Behaviour:
- Reset values: avg_data=0, avg_valid=0, fifo_level=0, overflow_cnt=0. Internal sample count, accumulator and stage-1 valid are also 0.
- Stage 1, the edge ending cycle t with wrena=1:
  - s1_val <= (int_part << FRAC_SHIFT) + frac_part, zero-extended to COMB_W.
  - s1_v <= 1; otherwise s1_v <= 0.
- Stage 2, the edge ending cycle t+1 with s1_v=1:
  - If sample count < 2^LOG2_N - 1: acc <= acc + s1_val and count++.
  - If sample count = 2^LOG2_N - 1 (last sample of the block): the mean (acc + s1_val + 2^(LOG2_N-1)) >> LOG2_N is pushed to the FIFO, then acc <= 0 and count <= 0.
  - If LOG2_N = 0, there is no rounding term and every sample is pushed directly.
- Accumulator width: ACC_W = COMB_W + LOG2_N. No overflow is possible by construction.
- Back-to-back strobes (wrena high every cycle) are fully supported; no stall is required.
- FIFO timing:
  - First-word-fall-through: a push into an empty FIFO gives avg_valid=1 with avg_data valid in the next cycle, i.e. cycle t+2 for the final sample's wrena at cycle t.
  - Total latency from the last strobe to avg_valid is 2 cycles.
  - avg_data holds the head entry while avg_valid=1 and avg_ready=0.
- FIFO full and push, no pop in the same cycle: the mean is discarded, overflow_cnt increments (saturating), and acc/count still restart.
- FIFO full with simultaneous push and pop: the push is accepted, and fifo_level stays at its maximum.
- FIFO empty with avg_ready=1: no effect.
- Pointers wrap modulo depth. fifo_level is tracked separately to distinguish full from empty.
- clear=1 in any cycle, on the next edge:
  - s1_v, acc, count, all FIFO pointers, fifo_level and overflow_cnt go to 0, and avg_valid goes to 0.
  - clear has priority over wrena, a push and a pop in the same cycle; samples in flight are discarded.
- Async reset mid-block: all state clears immediately, and the partial block is lost.

Optional Feature:
- TDC_AVG_MINMAX_EN defined:
  - Adds outputs blk_min and blk_max (COMB_W each, reset 0), updated on every push, including dropped pushes, with the min/max of the raw s1_val over the just-completed block.
  - The running min initialises to all-ones and the max to 0 at block start and on clear.
- Undefined: no min/max ports or logic.

Decomposition:
- Package tdc_avg_pkg holds:
  - localparams COMB_W and ACC_W as functions of the parameters;
  - typedef comb_t, logic[COMB_W-1:0];
  - the OVF_SAT constant, 255.
- One sub-module, tdc_avg_fifo: a parameterised FWFT FIFO providing push, pop, flush, level and full/empty.

Test Plan (defaults unless stated; LOG2_N=2, FRAC_SHIFT=6):
- Basic mean: 4 strobes with (int=3,frac=10), (3,14), (3,18), (3,22) → values 202, 206, 210, 214 → one push, avg_data=208, avg_valid 2 cycles after the 4th strobe.
- Rounding: samples 202, 202, 203, 203 → avg_data=203; samples 202, 202, 202, 203 → avg_data=202.
- Back-to-back: wrena high for 16 consecutive cycles at a constant value 100 → 4 entries equal to 100, fifo_level=4, no overflow.
- Overflow: avg_ready=0 with 10 blocks → fifo_level=8 and overflow_cnt=2; then pop 8 → the data order matches blocks 1..8.
- Full with simultaneous push and pop: FIFO full, avg_ready=1 in the cycle a push arrives → level stays 8 and overflow_cnt is unchanged.
- Clear: clear asserted in the same cycle as the 3rd strobe of a block → next block needs 4 fresh samples, FIFO is empty and overflow_cnt=0; async reset low mid-stream → all outputs 0 immediately.
